pmem_burst_responder: RTL and testbench



---
 rtl/pmem_burst_responder.sv | 158 +++++++++++++++
 tb/tb_pmem_burst_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_burst_responder.sv
// pmem_burst_responder: memory-side responder for the 8-beat, 32-bit line
// burst protocol. A line-aligned read or write request is served as BEATS
// contiguous mem_resp beats, LATENCY cycles after acceptance. Storage is an
// internal word array with a registered read port. Array contents survive reset.
// Optional build macro: PMEM_BYTE_ENABLE_EN (per-byte write strobes).
module pmem_burst_responder #(
  parameter int LATENCY     = 4,
  parameter int DEPTH_WORDS = 1024,
  parameter int BEATS       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Full word index before the modulo: line base concatenated with beat number
  localparam int LW = 27 + BW;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  state_t         state_reg, state_next;
  logic           op_write_reg;
  logic [26:0]    base_reg;
  logic [7:0]     lat_cnt_reg;
  logic [BW-1:0]  beat_reg;
  logic           err_reg;
  logic [31:0]    rdata_reg;

  logic [31:0]    mem_array [DEPTH_WORDS];

  logic           req_single;
  logic           req_both;
  logic           req_held;
  logic           last_beat;
  logic           accept;
  logic           err_set;
  logic           wr_en;
  logic           rd_en;
  logic [BW-1:0]  beat_next;
  logic [26:0]    base_sel;
  logic [LW-1:0]  rd_full;
  logic [LW-1:0]  wr_full;
  logic [AW-1:0]  rd_index;
  logic [AW-1:0]  wr_index;

  // Exactly one request line must be high; the latched op must stay the only one asserted
  assign req_single = mem_read ^ mem_write;
  assign req_both   = mem_read & mem_write;
  assign req_held   = op_write_reg ? (mem_write & ~mem_read) : (mem_read & ~mem_write);
  assign last_beat  = (beat_reg == BW'(BEATS - 1));
  assign accept     = (state_reg == IDLE) && req_single;

  // Address wrap is the low AW bits of base*BEATS + beat
  assign rd_full  = {base_sel, beat_next};
  assign wr_full  = {base_reg, beat_reg};
  assign rd_index = rd_full[AW-1:0];
  assign wr_index = wr_full[AW-1:0];

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_single) state_next = (LATENCY == 1) ? BURST : WAIT;
      WAIT:    if (!req_held) state_next = IDLE;
               else if (lat_cnt_reg <= 8'd1) state_next = BURST;
      BURST:   if (!req_held) state_next = IDLE;
               else if (last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs and datapath controls decoded from state and request lines
  always_comb begin
    err_set   = 1'b0;
    mem_resp  = 1'b0;
    case (state_reg)
      IDLE:    err_set = req_both;
      WAIT:    err_set = ~req_held;
      BURST:   begin
                 err_set  = ~req_held;
                 mem_resp = req_held;
               end
      DONE:    err_set = mem_read | mem_write;
      default: err_set = 1'b0;
    endcase
    wr_en     = mem_resp & op_write_reg;
    // Prefetch the next beat so read data leaves the array register aligned with mem_resp
    rd_en     = (state_next == BURST) && ((state_reg == IDLE) ? mem_read : ~op_write_reg);
    beat_next = (state_reg == BURST) ? beat_reg + BW'(1) : '0;
    base_sel  = (state_reg == IDLE) ? mem_address[31:5] : base_reg;
    mem_rdata = (mem_resp && !op_write_reg) ? rdata_reg : 32'd0;
  end

  // State register, request latch, counters and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      op_write_reg <= 1'b0;
      base_reg     <= '0;
      lat_cnt_reg  <= '0;
      beat_reg     <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_write_reg <= mem_write;
        base_reg     <= mem_address[31:5];
        lat_cnt_reg  <= 8'(LATENCY - 1);
      end else if (state_reg == WAIT) begin
        lat_cnt_reg  <= lat_cnt_reg - 8'd1;
      end else begin
        lat_cnt_reg  <= '0;
      end
      beat_reg <= (state_next == BURST) ? beat_next : '0;
      err_reg  <= err_reg | err_set;
    end
  end

  // Registered array read feeding mem_rdata
  always_ff @(posedge clk) begin
    if (!rst) rdata_reg <= '0;
    else if (rd_en) rdata_reg <= mem_array[rd_index];
  end

  // Array write at the end of each accepted write beat
  always_ff @(posedge clk) begin
`ifdef PMEM_BYTE_ENABLE_EN
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byte_enable[b]) mem_array[wr_index][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
`else
    if (wr_en) mem_array[wr_index] <= mem_wdata;
`endif
  end

  assign err = err_reg;

  // Address bits below the line and above the array depth carry no information
  logic unused;
`ifdef PMEM_BYTE_ENABLE_EN
  assign unused = &{1'b0, mem_address[4:0], rd_full[LW-1:AW], wr_full[LW-1:AW]};
`else
  assign unused = &{1'b0, mem_address[4:0], rd_full[LW-1:AW], wr_full[LW-1:AW], mem_byte_enable};
`endif

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Self-checking bench for pmem_burst_responder: directed protocol scenarios
// followed by randomized bursts, checked against a word-array reference model.
module tb_pmem_burst_responder;

  localparam int LATENCY = 4;
  localparam int DEPTH   = 1024;
  localparam int BEATS   = 8;
  localparam int LB      = LATENCY + BEATS;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_address = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_byte_enable = '0;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        err;

  always #5 clk = ~clk;

  pmem_burst_responder #(
    .LATENCY(LATENCY),
    .DEPTH_WORDS(DEPTH),
    .BEATS(BEATS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_address(mem_address),
    .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp),
    .mem_rdata(mem_rdata),
    .err(err)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem   [DEPTH];
  bit          ref_known [DEPTH];
  bit          err_exp = 1'b0;

  logic [31:0] tx_data [BEATS];
  logic [3:0]  tx_be   [BEATS];
  logic [31:0] rd_cap  [BEATS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
    end
  endtask

  function automatic int word_idx(input logic [31:0] addr, input int beat);
    longint line;
    line = longint'(addr >> 5);
    return int'((line * BEATS + beat) % DEPTH);
  endfunction

  task automatic ref_write(input int idx, input logic [31:0] data, input logic [3:0] be);
`ifdef PMEM_BYTE_ENABLE_EN
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
    if (be == 4'hF) ref_known[idx] = 1'b1;
`else
    ref_mem[idx]   = data;
    ref_known[idx] = 1'b1;
    if (be === 4'hx) ref_known[idx] = 1'b1;
`endif
  endtask

  task automatic set_line(input logic [31:0] start, input logic [31:0] step);
    for (int k = 0; k < BEATS; k++) begin
      tx_data[k] = start + step * k;
      tx_be[k]   = 4'hF;
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      mem_address = $urandom(); mem_wdata = $urandom();
      @(negedge clk);
      chk("idle resp", 32'(mem_resp), 32'd0);
      chk("idle rdata", mem_rdata, 32'd0);
      chk("idle err", 32'(err), 32'(err_exp));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset resp", 32'(mem_resp), 32'd0);
    chk("reset rdata", mem_rdata, 32'd0);
    chk("reset err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    err_exp = 1'b0;
    @(negedge clk);
    chk("post-reset err", 32'(err), 32'd0);
  endtask

  // One transaction from request to DONE; request is held for offsets < drop_at.
  // Expected beats occupy offsets LATENCY..LATENCY+BEATS-1 while the request is held.
  task automatic xact(input bit wr, input logic [31:0] addr, input int drop_at, input string tag);
    int  beat;
    int  idx;
    bit  held;
    bit  in_burst;
    for (int o = 0; o <= LB; o++) begin
      beat     = o - LATENCY;
      held     = (o < drop_at);
      in_burst = held && (beat >= 0) && (beat < BEATS);
      @(posedge clk); #1;
      mem_read        = held && !wr;
      mem_write       = held && wr;
      mem_address     = (o == 0) ? addr : $urandom();
      mem_wdata       = in_burst ? tx_data[beat] : $urandom();
      mem_byte_enable = in_burst ? tx_be[beat] : 4'($urandom());
      @(negedge clk);
      chk($sformatf("%s resp@%0d", tag, o), 32'(mem_resp), 32'(in_burst));
      if (in_burst && !wr) begin
        idx = word_idx(addr, beat);
        rd_cap[beat] = mem_rdata;
        if (ref_known[idx]) chk($sformatf("%s rdata b%0d", tag, beat), mem_rdata, ref_mem[idx]);
      end else begin
        chk($sformatf("%s rdata-zero@%0d", tag, o), mem_rdata, 32'd0);
      end
      if (in_burst && wr) ref_write(word_idx(addr, beat), tx_data[beat], tx_be[beat]);
    end
    if (drop_at != LB) err_exp = 1'b1;
  endtask

  initial begin
    bit          wr;
    int          sel;
    int          drop;
    logic [31:0] addr;
    logic [31:0] be_exp;

    for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;

    // Reset and quiet idle
    do_reset();
    idle(10);

    // Write then read line 0x40; then read with ignored low address bits
    set_line(32'h11111111, 32'h11111111);
    xact(1'b1, 32'h0000_0040, LB, "wr40");
    idle(1);
    xact(1'b0, 32'h0000_0040, LB, "rd40");
    for (int k = 0; k < BEATS; k++) chk("rd40 const", rd_cap[k], 32'h11111111 * (k + 1));
    xact(1'b0, 32'h0000_005C, LB, "rd5c");
    for (int k = 0; k < BEATS; k++) chk("rd5c const", rd_cap[k], 32'h11111111 * (k + 1));

    // Aliasing beyond the array, issued back-to-back
    set_line(32'hC0DE0000, 32'd1);
    xact(1'b1, 32'h0000_1000, LB, "wr1000");
    xact(1'b0, 32'h0000_0000, LB, "rd0");
    for (int k = 0; k < BEATS; k++) chk("alias const", rd_cap[k], 32'hC0DE0000 + k);

    // Both request lines high: no response, sticky error
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b1; mem_address = 32'h40;
    @(negedge clk);
    chk("both resp", 32'(mem_resp), 32'd0);
    err_exp = 1'b1;
    idle(LATENCY + 2);
    do_reset();

    // Write abort after beat 3
    set_line(32'hA0A0A0A0, 32'd1);
    xact(1'b1, 32'h0000_0080, LB, "wrA");
    idle(1);
    chk("no err before abort", 32'(err), 32'd0);
    set_line(32'hB0B0B0B0, 32'd1);
    xact(1'b1, 32'h0000_0080, LATENCY + 4, "abort");
    idle(2);
    xact(1'b0, 32'h0000_0080, LB, "rdabort");
    for (int k = 0; k < BEATS; k++)
      chk("abort const", rd_cap[k], (k < 4) ? 32'hB0B0B0B0 + k : 32'hA0A0A0A0 + k);
    idle(1);
    do_reset();

    // Abort during latency wait
    xact(1'b0, 32'h0000_0080, 2, "waitabort");
    idle(2);
    do_reset();

    // Request still high in DONE
    xact(1'b0, 32'h0000_0040, LB + 1, "donehold");
    idle(2);
    do_reset();

    // Byte strobes
    set_line(32'hAAAAAAAA, 32'd0);
    xact(1'b1, 32'h0000_0100, LB, "prefill");
    for (int k = 0; k < BEATS; k++) tx_be[k] = 4'b0000;
    tx_data[0] = 32'h12345678;
    tx_be[0]   = 4'b0101;
    xact(1'b1, 32'h0000_0100, LB, "bewr");
    xact(1'b0, 32'h0000_0100, LB, "berd");
`ifdef PMEM_BYTE_ENABLE_EN
    be_exp = 32'hAA34AA78;
`else
    be_exp = 32'h12345678;
`endif
    chk("byte-enable beat0", rd_cap[0], be_exp);
    for (int k = 1; k < BEATS; k++) chk("byte-enable rest", rd_cap[k], 32'hAAAAAAAA);
    idle(1);

    // Randomized bursts over a small set of lines with aliasing high bits
    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = (32'($urandom_range(0, 3)) << 15) | (32'($urandom_range(0, 15)) << 5)
             | 32'($urandom_range(0, 31));
      for (int k = 0; k < BEATS; k++) begin
        tx_data[k] = $urandom();
        tx_be[k]   = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'hF;
      end
      sel = $urandom_range(0, 9);
      if (sel == 0)      drop = $urandom_range(1, LB - 1);
      else if (sel == 1) drop = LB + 1;
      else               drop = LB;
      xact(wr, addr, drop, wr ? "rndwr" : "rndrd");
      if (drop == LB + 1 || (err_exp && $urandom_range(0, 2) == 0)) begin
        idle(1);
        do_reset();
      end else begin
        idle($urandom_range(0, 2));
      end
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
